// File: rtl/sm83_alu_pkg.sv
// rtl/sm83_alu_pkg.sv - operation encodings and flag constants for the SM83 ALU
package sm83_alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_ADC  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SBC  = 5'd3,
        ALU_AND  = 5'd4,
        ALU_OR   = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_CP   = 5'd7,
        ALU_INC  = 5'd8,
        ALU_DEC  = 5'd9,
        ALU_SWAP = 5'd10,
        ALU_DAA  = 5'd11,
        ALU_CPL  = 5'd12,
        ALU_CCF  = 5'd13,
        ALU_SCF  = 5'd14,
        ALU_RLC  = 5'd15,
        ALU_RL   = 5'd16,
        ALU_RRC  = 5'd17,
        ALU_RR   = 5'd18,
        ALU_SLA  = 5'd19,
        ALU_SRA  = 5'd20,
        ALU_SRL  = 5'd21,
        ALU_BIT  = 5'd22,
        ALU_SET  = 5'd23,
        ALU_RES  = 5'd24
    } alu_fun_t;

    // Bit positions within the {Z,N,H,C} flag nibble
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    localparam logic [3:0] Z_FLAG_SET = 4'b1000;
    localparam logic [3:0] N_FLAG_SET = 4'b0100;
    localparam logic [3:0] H_FLAG_SET = 4'b0010;
    localparam logic [3:0] C_FLAG_SET = 4'b0001;

endpackage

// File: rtl/sm83_alu.sv
// rtl/sm83_alu.sv - SM83 8-bit ALU with registered result and flags
module sm83_alu
    import sm83_alu_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] ALU_FUN,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] FLAGS_IN,
    output logic [7:0] ALU_OUT,
    output logic [3:0] FLAGS_OUT
);

    logic       cin;
    logic       ci;
    logic [8:0] add_sum;
    logic [4:0] add_half;
    logic [8:0] sub_diff;
    logic [4:0] sub_half;
    logic [7:0] bit_mask;
    logic [7:0] daa_adj;
    logic       daa_c;
    logic [7:0] res_d;
    logic [3:0] flg_d;

    assign cin = FLAGS_IN[FLAG_C];

    // Shared adder/subtractor datapath; carry-in only participates for ADC/SBC
    always_comb begin
        ci       = ((ALU_FUN == ALU_ADC) || (ALU_FUN == ALU_SBC)) ? cin : 1'b0;
        add_sum  = {1'b0, A} + {1'b0, B} + {8'b0, ci};
        add_half = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'b0, ci};
        sub_diff = {1'b0, A} - {1'b0, B} - {8'b0, ci};
        sub_half = {1'b0, A[3:0]} - {1'b0, B[3:0]} - {4'b0, ci};
        bit_mask = 8'd1 << B[2:0];
    end

    // DAA correction, both tests taken from the uncorrected accumulator
    always_comb begin
        daa_adj = 8'h00;
        daa_c   = cin;
        if (!FLAGS_IN[FLAG_N]) begin
            if (cin || (A > 8'h99)) begin
                daa_adj = daa_adj | 8'h60;
                daa_c   = 1'b1;
            end
            if (FLAGS_IN[FLAG_H] || (A[3:0] > 4'd9)) begin
                daa_adj = daa_adj | 8'h06;
            end
        end else begin
            if (cin) begin
                daa_adj = daa_adj | 8'h60;
            end
            if (FLAGS_IN[FLAG_H]) begin
                daa_adj = daa_adj | 8'h06;
            end
        end
    end

    // Operation select: result and next flags, pass-through by default
    always_comb begin
        res_d = A;
        flg_d = FLAGS_IN;
        case (ALU_FUN)
            ALU_ADD, ALU_ADC: begin
                res_d = add_sum[7:0];
                flg_d = {res_d == 8'h00, 1'b0, add_half[4], add_sum[8]};
            end
            ALU_SUB, ALU_SBC: begin
                res_d = sub_diff[7:0];
                flg_d = {res_d == 8'h00, 1'b1, sub_half[4], sub_diff[8]};
            end
            ALU_CP: begin
                res_d = A;
                flg_d = {sub_diff[7:0] == 8'h00, 1'b1, sub_half[4], sub_diff[8]};
            end
            ALU_AND: begin
                res_d = A & B;
                flg_d = {res_d == 8'h00, 1'b0, 1'b1, 1'b0};
            end
            ALU_OR: begin
                res_d = A | B;
                flg_d = {res_d == 8'h00, 3'b000};
            end
            ALU_XOR: begin
                res_d = A ^ B;
                flg_d = {res_d == 8'h00, 3'b000};
            end
            ALU_INC: begin
                res_d = A + 8'd1;
                flg_d = {res_d == 8'h00, 1'b0, A[3:0] == 4'hF, cin};
            end
            ALU_DEC: begin
                res_d = A - 8'd1;
                flg_d = {res_d == 8'h00, 1'b1, A[3:0] == 4'h0, cin};
            end
            ALU_SWAP: begin
                res_d = {A[3:0], A[7:4]};
                flg_d = {res_d == 8'h00, 3'b000};
            end
            ALU_DAA: begin
                res_d = FLAGS_IN[FLAG_N] ? (A - daa_adj) : (A + daa_adj);
                flg_d = {res_d == 8'h00, FLAGS_IN[FLAG_N], 1'b0, daa_c};
            end
            ALU_CPL: begin
                res_d = ~A;
                flg_d = {FLAGS_IN[FLAG_Z], 1'b1, 1'b1, cin};
            end
            ALU_CCF: begin
                flg_d = {FLAGS_IN[FLAG_Z], 1'b0, 1'b0, ~cin};
            end
            ALU_SCF: begin
                flg_d = {FLAGS_IN[FLAG_Z], 1'b0, 1'b0, 1'b1};
            end
            ALU_RLC: begin
                res_d = {A[6:0], A[7]};
                flg_d = {res_d == 8'h00, 2'b00, A[7]};
            end
            ALU_RL: begin
                res_d = {A[6:0], cin};
                flg_d = {res_d == 8'h00, 2'b00, A[7]};
            end
            ALU_RRC: begin
                res_d = {A[0], A[7:1]};
                flg_d = {res_d == 8'h00, 2'b00, A[0]};
            end
            ALU_RR: begin
                res_d = {cin, A[7:1]};
                flg_d = {res_d == 8'h00, 2'b00, A[0]};
            end
            ALU_SLA: begin
                res_d = {A[6:0], 1'b0};
                flg_d = {res_d == 8'h00, 2'b00, A[7]};
            end
            ALU_SRA: begin
                res_d = {A[7], A[7:1]};
                flg_d = {res_d == 8'h00, 2'b00, A[0]};
            end
            ALU_SRL: begin
                res_d = {1'b0, A[7:1]};
                flg_d = {res_d == 8'h00, 2'b00, A[0]};
            end
            ALU_BIT: begin
                flg_d = {(A & bit_mask) == 8'h00, 1'b0, 1'b1, cin};
            end
            ALU_SET: begin
                res_d = A | bit_mask;
            end
            ALU_RES: begin
                res_d = A & ~bit_mask;
            end
            default: begin
                res_d = A;
                flg_d = FLAGS_IN;
            end
        endcase
    end

    // Output register; reset wins over the computed value
    always_ff @(posedge CLK) begin
        if (RST) begin
            ALU_OUT   <= 8'h00;
            FLAGS_OUT <= 4'b0000;
        end else begin
            ALU_OUT   <= res_d;
            FLAGS_OUT <= flg_d;
        end
    end

endmodule

// File: tb/tb_sm83_alu.sv
// tb/tb_sm83_alu.sv - self-checking bench for sm83_alu
module tb_sm83_alu;

    logic       CLK;
    logic       RST;
    logic [4:0] ALU_FUN;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] FLAGS_IN;
    logic [7:0] ALU_OUT;
    logic [3:0] FLAGS_OUT;

    int checks;
    int failures;

    sm83_alu dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALU_FUN   (ALU_FUN),
        .A         (A),
        .B         (B),
        .FLAGS_IN  (FLAGS_IN),
        .ALU_OUT   (ALU_OUT),
        .FLAGS_OUT (FLAGS_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: plain integer arithmetic on the documented rules, returns {result, Z,N,H,C}
    function automatic logic [11:0] model(input int fun, input int a, input int b, input int f);
        int z, n, h, c, r, s, adj, bv;
        z = (f >> 3) & 1;
        n = (f >> 2) & 1;
        h = (f >> 1) & 1;
        c = f & 1;
        r = a;
        case (fun)
            0, 1: begin
                s = a + b + ((fun == 1) ? c : 0);
                h = ((a % 16) + (b % 16) + ((fun == 1) ? c : 0)) > 15 ? 1 : 0;
                c = (s > 255) ? 1 : 0;
                r = s % 256; n = 0; z = (r == 0) ? 1 : 0;
            end
            2, 3, 7: begin
                s = a - b - ((fun == 3) ? c : 0);
                h = ((a % 16) - (b % 16) - ((fun == 3) ? c : 0)) < 0 ? 1 : 0;
                c = (s < 0) ? 1 : 0;
                r = (s + 256) % 256; n = 1; z = (r == 0) ? 1 : 0;
                if (fun == 7) r = a;
            end
            4: begin r = a & b; z = (r == 0) ? 1 : 0; n = 0; h = 1; c = 0; end
            5: begin r = a | b; z = (r == 0) ? 1 : 0; n = 0; h = 0; c = 0; end
            6: begin r = a ^ b; z = (r == 0) ? 1 : 0; n = 0; h = 0; c = 0; end
            8: begin r = (a + 1) % 256; z = (r == 0) ? 1 : 0; n = 0; h = ((a % 16) == 15) ? 1 : 0; end
            9: begin r = (a + 255) % 256; z = (r == 0) ? 1 : 0; n = 1; h = ((a % 16) == 0) ? 1 : 0; end
            10: begin r = (a % 16) * 16 + a / 16; z = (r == 0) ? 1 : 0; n = 0; h = 0; c = 0; end
            11: begin
                adj = 0;
                if (n == 0) begin
                    if (c == 1 || a > 153) begin adj = adj + 96; c = 1; end
                    if (h == 1 || (a % 16) > 9) adj = adj + 6;
                    r = (a + adj) % 256;
                end else begin
                    adj = ((c == 1) ? 96 : 0) + ((h == 1) ? 6 : 0);
                    r = (a - adj + 256) % 256;
                end
                z = (r == 0) ? 1 : 0; h = 0;
            end
            12: begin r = 255 - a; n = 1; h = 1; end
            13: begin c = 1 - c; n = 0; h = 0; end
            14: begin c = 1; n = 0; h = 0; end
            15: begin r = (a * 2) % 256 + a / 128; c = a / 128; end
            16: begin r = (a * 2) % 256 + c; c = a / 128; end
            17: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
            18: begin r = a / 2 + c * 128; c = a % 2; end
            19: begin r = (a * 2) % 256; c = a / 128; end
            20: begin r = a / 2 + (a / 128) * 128; c = a % 2; end
            21: begin r = a / 2; c = a % 2; end
            22: begin bv = (a >> (b % 8)) & 1; z = 1 - bv; n = 0; h = 1; end
            23: r = a | (1 << (b % 8));
            24: r = a & (255 - (1 << (b % 8)));
            default: r = a;
        endcase
        if (fun >= 15 && fun <= 21) begin
            z = (r == 0) ? 1 : 0; n = 0; h = 0;
        end
        model = {r[7:0], z[0], n[0], h[0], c[0]};
    endfunction

    task automatic drive(input int fun, input int a, input int b, input int f);
        ALU_FUN  = fun[4:0];
        A        = a[7:0];
        B        = b[7:0];
        FLAGS_IN = f[3:0];
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive($urandom_range(0, 31), $urandom_range(1, 255), $urandom_range(0, 255), $urandom_range(1, 15));
            checks++;
            if (ALU_OUT !== 8'h00 || FLAGS_OUT !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold: got %h/%b want 00/0000", ALU_OUT, FLAGS_OUT);
            end
        end
        RST = 1'b0;
        drive(0, 8'h12, 8'h34, 0);
        checks++;
        if (ALU_OUT !== 8'h46 || FLAGS_OUT !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release: got %h/%b want 46/0000", ALU_OUT, FLAGS_OUT);
        end
    endtask

    typedef struct {
        string name;
        int fun; int a; int b; int f;
        logic [7:0] res; logic [3:0] flg;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{"add",  0, 'h45, 'h69, 'b0000, 8'hAE, 4'b0000});
        v.push_back('{"adc",  1, 'h45, 'h69, 'b0001, 8'hAF, 4'b0000});
        v.push_back('{"sub",  2, 'h69, 'h45, 'b0000, 8'h24, 4'b0100});
        v.push_back('{"sbc",  3, 'h69, 'h45, 'b0001, 8'h23, 4'b0100});
        v.push_back('{"add_wrap", 0, 'hFF, 'h01, 'b0000, 8'h00, 4'b1011});
        v.push_back('{"cp",   7, 'h1F, 'h1F, 'b0000, 8'h1F, 4'b1100});
        v.push_back('{"and",  4, 'hFF, 'h0F, 'b0100, 8'h0F, 4'b0010});
        v.push_back('{"or",   5, 'h1F, 'h3A, 'b0000, 8'h3F, 4'b0000});
        v.push_back('{"xor",  6, 'h1F, 'h3A, 'b0001, 8'h25, 4'b0000});
        v.push_back('{"inc",  8, 'h2F, 'h00, 'b0100, 8'h30, 4'b0010});
        v.push_back('{"dec",  9, 'h1F, 'h00, 'b0000, 8'h1E, 4'b0100});
        v.push_back('{"swap", 10, 'h96, 'h00, 'b0001, 8'h69, 4'b0000});
        v.push_back('{"daa_h", 11, 'h21, 'h00, 'b0010, 8'h27, 4'b0000});
        v.push_back('{"daa_wrap", 11, 'h9A, 'h00, 'b0000, 8'h00, 4'b1001});
        v.push_back('{"cpl",  12, 'h0F, 'h00, 'b0000, 8'hF0, 4'b0110});
        v.push_back('{"ccf",  13, 'h0F, 'h00, 'b1111, 8'h0F, 4'b1000});
        v.push_back('{"scf",  14, 'h0F, 'h00, 'b0000, 8'h0F, 4'b0001});
        v.push_back('{"rlc",  15, 'h93, 'h00, 'b0000, 8'h27, 4'b0001});
        v.push_back('{"rl",   16, 'h53, 'h00, 'b0001, 8'hA7, 4'b0000});
        v.push_back('{"rrc",  17, 'h53, 'h00, 'b0000, 8'hA9, 4'b0001});
        v.push_back('{"rr",   18, 'h52, 'h00, 'b1111, 8'hA9, 4'b0000});
        v.push_back('{"sla",  19, 'h53, 'h00, 'b0000, 8'hA6, 4'b0000});
        v.push_back('{"sra",  20, 'hD3, 'h00, 'b0000, 8'hE9, 4'b0001});
        v.push_back('{"srl",  21, 'h52, 'h00, 'b0000, 8'h29, 4'b0000});
        v.push_back('{"bit",  22, 'hF7, 'h03, 'b1111, 8'hF7, 4'b1011});
        v.push_back('{"set",  23, 'h0F, 'h06, 'b0000, 8'h4F, 4'b0000});
        v.push_back('{"res",  24, 'hFF, 'h07, 'b1111, 8'h7F, 4'b1111});
        v.push_back('{"unused31", 31, 'h5C, 'h33, 'b1010, 8'h5C, 4'b1010});
        foreach (v[i]) begin
            drive(v[i].fun, v[i].a, v[i].b, v[i].f);
            checks++;
            if (ALU_OUT !== v[i].res || FLAGS_OUT !== v[i].flg) begin
                failures++;
                $display("FAIL %s: got %h/%b want %h/%b", v[i].name, ALU_OUT, FLAGS_OUT, v[i].res, v[i].flg);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] exp;
        int fun, a, b, f;
        for (int i = 0; i < 3000; i++) begin
            fun = $urandom_range(0, 31);
            a   = $urandom_range(0, 255);
            b   = $urandom_range(0, 255);
            f   = $urandom_range(0, 15);
            exp = model(fun, a, b, f);
            drive(fun, a, b, f);
            checks++;
            if ({ALU_OUT, FLAGS_OUT} !== exp) begin
                failures++;
                $display("FAIL random fun=%0d a=%h b=%h f=%b: got %h/%b want %h/%b",
                         fun, a, b, f, ALU_OUT, FLAGS_OUT, exp[11:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp;
        int fun, a, b, f;
        for (int i = 0; i < 200; i++) begin
            fun = $urandom_range(0, 24);
            a   = $urandom_range(0, 255);
            b   = $urandom_range(0, 255);
            f   = $urandom_range(0, 15);
            exp = model(fun, a, b, f);
            drive(fun, a, b, f);
            ALU_FUN  = 5'($urandom_range(0, 31));
            A        = ~A;
            B        = 8'($urandom_range(0, 255));
            FLAGS_IN = ~FLAGS_IN;
            #3;
            checks++;
            if ({ALU_OUT, FLAGS_OUT} !== exp) begin
                failures++;
                $display("FAIL hold fun=%0d a=%h: got %h/%b want %h/%b",
                         fun, a, ALU_OUT, FLAGS_OUT, exp[11:4], exp[3:0]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [11:0] exp;
        drive(0, 8'h80, 8'h80, 0);
        RST = 1'b1;
        drive(5, 8'hA5, 8'h5A, 4'b0111);
        checks++;
        if (ALU_OUT !== 8'h00 || FLAGS_OUT !== 4'b0000) begin
            failures++;
            $display("FAIL reset_midstream: got %h/%b want 00/0000", ALU_OUT, FLAGS_OUT);
        end
        RST = 1'b0;
        exp = model(9, 8'h00, 0, 4'b0001);
        drive(9, 8'h00, 0, 4'b0001);
        checks++;
        if ({ALU_OUT, FLAGS_OUT} !== exp) begin
            failures++;
            $display("FAIL reset_recover: got %h/%b want %h/%b", ALU_OUT, FLAGS_OUT, exp[11:4], exp[3:0]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        ALU_FUN  = 5'd0;
        A        = 8'h00;
        B        = 8'h00;
        FLAGS_IN = 4'b0000;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
